// File: rtl/fairy_muldiv_ctrl_pkg.sv
// Shared definitions for the fairy multiply/divide controller.
//   - MDU op encodings as presented on op_i
//   - controller state encodings and the typed state enum
//   - DIV_STEPS: number of restoring-divide iterations
//   - abs32: two's complement magnitude helper
package fairy_muldiv_ctrl_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  localparam logic [1:0] MDU_IDLE     = 2'd0;
  localparam logic [1:0] MDU_MUL_WAIT = 2'd1;
  localparam logic [1:0] MDU_DIV_ITER = 2'd2;
  localparam logic [1:0] MDU_FIN      = 2'd3;

  localparam int unsigned DIV_STEPS = 32;

  typedef enum logic [1:0] {
    StIdle    = MDU_IDLE,
    StMulWait = MDU_MUL_WAIT,
    StDivIter = MDU_DIV_ITER,
    StFin     = MDU_FIN
  } mdu_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/fairy_div_step.sv
// One restoring-divide step (combinational).
//   rem_i : partial remainder (always < div_i)
//   quo_i : quotient/dividend shift register; its MSB is the next dividend bit
//   div_i : divisor magnitude
//   rem_o : next partial remainder
//   quo_o : quotient register shifted left with the new quotient bit in bit 0
module fairy_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[31]};
    fits    = shifted >= {1'b0, div_i};
    // When it fits the difference is below the divisor, so 32 bits are enough.
    diff    = shifted[31:0] - div_i;
    if (fits) begin
      rem_o = diff;
      quo_o = {quo_i[30:0], 1'b1};
    end else begin
      rem_o = shifted[31:0];
      quo_o = {quo_i[30:0], 1'b0};
    end
  end

endmodule

// File: rtl/fairy_muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer beside the execute stage.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_i, op_i       issue request; op 0=MULT 1=MULTU 2=DIV 3=DIVU
//   src_a_i, src_b_i    rs (dividend) / rt (divisor) operands
//   flush_i             writeback exception, cancels any in-flight op
//   hilo_we_i/sel_i/wdata_i  writeback MTHI/MTLO write (sel 0=LO 1=HI)
//   rd_req_i            MFHI/MFLO in execute
//   busy_o, stall_o     op in flight; read stall (rd_req_i & busy_o)
//   hi_o, lo_o          HI/LO registers
//
// Parameter MUL_LAT (1..7): cycles the registered product waits in MUL_WAIT.
// Build option FAIRY_DIV_EARLY_EXIT_EN: divides with a zero divisor or a
// dividend magnitude below the divisor magnitude skip the iteration phase.
module fairy_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  input  logic        hilo_we_i,
  input  logic        hilo_sel_i,
  input  logic [31:0] hilo_wdata_i,
  input  logic        rd_req_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  import fairy_muldiv_ctrl_pkg::*;

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // acc_hi holds the partial remainder / product high half,
  // acc_lo the quotient shift register / product low half.
  logic [31:0] acc_hi_q, acc_hi_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] dividend_q, dividend_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        op_signed;
  logic        op_is_div;
  logic [31:0] mag_a, mag_b;
  logic [63:0] ext_a, ext_b, prod;
  logic        early_exit;
  logic [31:0] step_rem, step_quo;
  logic        fin_we;
  logic [31:0] fin_hi, fin_lo;

  // Operand preparation for the accept cycle.
  always_comb begin
    op_signed = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    op_is_div = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    mag_a     = op_signed ? abs32(src_a_i) : src_a_i;
    mag_b     = op_signed ? abs32(src_b_i) : src_b_i;
    // Sign/zero extension to 64 bits makes one truncated multiply serve both ops.
    ext_a     = {(op_signed ? {32{src_a_i[31]}} : 32'd0), src_a_i};
    ext_b     = {(op_signed ? {32{src_b_i[31]}} : 32'd0), src_b_i};
    prod      = ext_a * ext_b;
  end

`ifdef FAIRY_DIV_EARLY_EXIT_EN
  assign early_exit = (mag_b == 32'd0) || (mag_a < mag_b);
`else
  assign early_exit = 1'b0;
`endif

  assign accept = start_i & (state_q == StIdle) & ~flush_i;

  fairy_div_step u_div_step (
    .rem_i (acc_hi_q),
    .quo_i (acc_lo_q),
    .div_i (divisor_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dbz_d      = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_is_div) begin
            acc_hi_d   = 32'd0;
            acc_lo_d   = mag_a;
            divisor_d  = mag_b;
            dividend_d = src_a_i;
            q_neg_d    = op_signed & (src_a_i[31] ^ src_b_i[31]);
            r_neg_d    = op_signed & src_a_i[31];
            dbz_d      = (src_b_i == 32'd0);
            cnt_d      = 5'(DIV_STEPS - 1);
            if (early_exit) begin
              // Quotient 0, remainder |a|; the sign fix restores the signed dividend.
              acc_hi_d = mag_a;
              acc_lo_d = 32'd0;
              state_d  = StFin;
            end else begin
              state_d  = StDivIter;
            end
          end else begin
            acc_hi_d = prod[63:32];
            acc_lo_d = prod[31:0];
            q_neg_d  = 1'b0;
            r_neg_d  = 1'b0;
            dbz_d    = 1'b0;
            cnt_d    = 5'(MUL_LAT - 1);
            state_d  = StMulWait;
          end
        end
      end
      StMulWait: begin
        if (cnt_q == 5'd0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StDivIter: begin
        acc_hi_d = step_rem;
        acc_lo_d = step_quo;
        if (cnt_q == 5'd0) begin
          state_d = StFin;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (flush_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // Result formatting and HI/LO write-port arbitration.
  always_comb begin
    fin_we = (state_q == StFin) & ~flush_i;
    if (dbz_q) begin
      fin_hi = dividend_q;
      fin_lo = 32'hFFFF_FFFF;
    end else begin
      fin_hi = r_neg_q ? (32'd0 - acc_hi_q) : acc_hi_q;
      fin_lo = q_neg_q ? (32'd0 - acc_lo_q) : acc_lo_q;
    end

    hi_d = hi_q;
    lo_d = lo_q;
    if (hilo_we_i && hilo_sel_i) begin
      hi_d = hilo_wdata_i;
    end else if (fin_we) begin
      hi_d = fin_hi;
    end
    if (hilo_we_i && !hilo_sel_i) begin
      lo_d = hilo_wdata_i;
    end else if (fin_we) begin
      lo_d = fin_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      acc_hi_q   <= 32'd0;
      acc_lo_q   <= 32'd0;
      divisor_q  <= 32'd0;
      dividend_q <= 32'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign stall_o = rd_req_i & busy_o;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_fairy_muldiv_ctrl.sv
// Directed self-checking bench for fairy_muldiv_ctrl.
module tb_fairy_muldiv_ctrl;

  localparam int MUL_LAT = 2;
`ifdef FAIRY_DIV_EARLY_EXIT_EN
  localparam int EARLY_BUSY = 1;
`else
  localparam int EARLY_BUSY = 33;
`endif

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        hilo_we_i;
  logic        hilo_sel_i;
  logic [31:0] hilo_wdata_i;
  logic        rd_req_i;
  logic        busy_o;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  fairy_muldiv_ctrl #(
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .op_i         (op_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .flush_i      (flush_i),
    .hilo_we_i    (hilo_we_i),
    .hilo_sel_i   (hilo_sel_i),
    .hilo_wdata_i (hilo_wdata_i),
    .rd_req_i     (rd_req_i),
    .busy_o       (busy_o),
    .stall_o      (stall_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are checked at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rd_req_i = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_busy: got %b want 0", busy_o);
    end
    vec_cnt++;
    if (stall_o !== 1'b0) begin
      err_cnt++; $display("FAIL reset_stall: got %b want 0", stall_o);
    end
    vec_cnt++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
      err_cnt++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi_o, lo_o);
    end
    next_cycle();
    reset    = 1'b0;
    rd_req_i = 1'b0;
  endtask

  // MULT with MFHI/MFLO pending every cycle and a second start while busy.
  task automatic test_mult_stall();
    logic exp_busy;
    next_cycle();
    start_i = 1'b1; op_i = 2'd0; src_a_i = 32'hFFFF_FFFE; src_b_i = 32'd3;
    rd_req_i = 1'b1;
    for (int k = 1; k <= MUL_LAT + 3; k++) begin
      next_cycle();
      start_i = (k == 2);
      if (k == 2) begin
        op_i = 2'd1; src_a_i = 32'd5; src_b_i = 32'd5;
      end
      @(negedge clk);
      exp_busy = (k <= MUL_LAT + 1);
      vec_cnt++;
      if (busy_o !== exp_busy) begin
        err_cnt++; $display("FAIL mult_busy k=%0d: got %b want %b", k, busy_o, exp_busy);
      end
      vec_cnt++;
      if (stall_o !== exp_busy) begin
        err_cnt++; $display("FAIL mult_stall k=%0d: got %b want %b", k, stall_o, exp_busy);
      end
      if (k >= MUL_LAT + 2) begin
        vec_cnt++;
        if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFA) begin
          err_cnt++;
          $display("FAIL mult_result k=%0d: got %h/%h want ffffffff/fffffffa", k, hi_o, lo_o);
        end
      end
    end
    rd_req_i = 1'b0;
  endtask

  // Table of divide and multiply ops: busy length and final HI/LO.
  task automatic test_ops();
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    int          nb;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin op = 2'd3; a = 32'd100; b = 32'd7; nb = 33; eh = 32'd2; el = 32'hE; end
        1: begin op = 2'd2; a = 32'hFFFF_FFF9; b = 32'd2; nb = 33;
                 eh = 32'hFFFF_FFFF; el = 32'hFFFF_FFFD; end
        2: begin op = 2'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; nb = 33;
                 eh = 32'd0; el = 32'h8000_0000; end
        3: begin op = 2'd3; a = 32'd5; b = 32'd0; nb = EARLY_BUSY;
                 eh = 32'd5; el = 32'hFFFF_FFFF; end
        4: begin op = 2'd2; a = 32'd3; b = 32'd10; nb = EARLY_BUSY; eh = 32'd3; el = 32'd0; end
        5: begin op = 2'd2; a = 32'hFFFF_FFFD; b = 32'd10; nb = EARLY_BUSY;
                 eh = 32'hFFFF_FFFD; el = 32'd0; end
        6: begin op = 2'd2; a = 32'hFFFF_FFF9; b = 32'd0; nb = EARLY_BUSY;
                 eh = 32'hFFFF_FFF9; el = 32'hFFFF_FFFF; end
        7: begin op = 2'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; nb = MUL_LAT + 1;
                 eh = 32'd0; el = 32'd1; end
        default: begin op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; nb = MUL_LAT + 1;
                 eh = 32'hFFFF_FFFE; el = 32'd1; end
      endcase
      next_cycle();
      start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
      for (int k = 1; k <= nb + 1; k++) begin
        next_cycle();
        start_i = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (busy_o !== (k <= nb)) begin
          err_cnt++;
          $display("FAIL op%0d_busy k=%0d: got %b want %b", i, k, busy_o, (k <= nb));
        end
      end
      vec_cnt++;
      if (hi_o !== eh || lo_o !== el) begin
        err_cnt++;
        $display("FAIL op%0d_result: got %h/%h want %h/%h", i, hi_o, lo_o, eh, el);
      end
    end
  endtask

  task automatic test_flush();
    next_cycle();
    hilo_we_i = 1'b1; hilo_sel_i = 1'b1; hilo_wdata_i = 32'hAAAA;
    next_cycle();
    hilo_sel_i = 1'b0; hilo_wdata_i = 32'h5555;
    next_cycle();
    hilo_we_i = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (hi_o !== 32'hAAAA || lo_o !== 32'h5555) begin
      err_cnt++; $display("FAIL flush_preload: got %h/%h want aaaa/5555", hi_o, lo_o);
    end
    next_cycle();
    start_i = 1'b1; op_i = 2'd3; src_a_i = 32'd100; src_b_i = 32'd7;
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      start_i = 1'b0;
      flush_i = (k == 10);
    end
    @(negedge clk);
    vec_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++; $display("FAIL flush_busy: got %b want 0", busy_o);
    end
    repeat (30) next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (hi_o !== 32'hAAAA || lo_o !== 32'h5555) begin
      err_cnt++; $display("FAIL flush_hilo: got %h/%h want aaaa/5555", hi_o, lo_o);
    end
    next_cycle();
    start_i = 1'b1; flush_i = 1'b1; op_i = 2'd1; src_a_i = 32'd3; src_b_i = 32'd3;
    next_cycle();
    start_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if (busy_o !== 1'b0) begin
      err_cnt++; $display("FAIL flush_start_same_cycle: got busy %b want 0", busy_o);
    end
    repeat (MUL_LAT + 2) next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (hi_o !== 32'hAAAA || lo_o !== 32'h5555) begin
      err_cnt++; $display("FAIL flush_start_hilo: got %h/%h want aaaa/5555", hi_o, lo_o);
    end
  endtask

  task automatic test_wb_arb();
    next_cycle();
    hilo_we_i = 1'b1; hilo_sel_i = 1'b1; hilo_wdata_i = 32'hBEEF;
    next_cycle();
    hilo_sel_i = 1'b0; hilo_wdata_i = 32'hDEAD;
    next_cycle();
    hilo_we_i = 1'b0;
    // Writeback HI write in the FIN cycle wins HI; LO still takes the result.
    start_i = 1'b1; op_i = 2'd1; src_a_i = 32'h1_0000; src_b_i = 32'h1_0000;
    for (int k = 1; k <= MUL_LAT + 2; k++) begin
      next_cycle();
      start_i      = 1'b0;
      hilo_we_i    = (k == MUL_LAT + 1);
      hilo_sel_i   = 1'b1;
      hilo_wdata_i = 32'h1234;
    end
    @(negedge clk);
    vec_cnt++;
    if (hi_o !== 32'h1234 || lo_o !== 32'd0) begin
      err_cnt++; $display("FAIL wb_in_fin: got %h/%h want 00001234/00000000", hi_o, lo_o);
    end
    // Early writeback write is visible at once, then overwritten by FIN.
    next_cycle();
    start_i = 1'b1;
    for (int k = 1; k <= MUL_LAT + 2; k++) begin
      next_cycle();
      start_i      = 1'b0;
      hilo_we_i    = (k == 1);
      hilo_wdata_i = 32'h5678;
      if (k == 2) begin
        @(negedge clk);
        vec_cnt++;
        if (hi_o !== 32'h5678) begin
          err_cnt++; $display("FAIL wb_early_applied: got %h want 00005678", hi_o);
        end
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (hi_o !== 32'd1 || lo_o !== 32'd0) begin
      err_cnt++; $display("FAIL wb_early_overwrite: got %h/%h want 00000001/00000000", hi_o, lo_o);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    start_i = 1'b1; op_i = 2'd0; src_a_i = 32'd2; src_b_i = 32'd3;
    for (int k = 1; k <= 2 * MUL_LAT + 4; k++) begin
      next_cycle();
      start_i = (k == MUL_LAT + 2);
      op_i = 2'd1; src_a_i = 32'd7; src_b_i = 32'd6;
      @(negedge clk);
      if (k == MUL_LAT + 2) begin
        vec_cnt++;
        if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd6) begin
          err_cnt++;
          $display("FAIL b2b_first: got busy %b %h/%h want 0 0/6", busy_o, hi_o, lo_o);
        end
      end
      if (k == MUL_LAT + 3) begin
        vec_cnt++;
        if (busy_o !== 1'b1) begin
          err_cnt++; $display("FAIL b2b_accept: got busy %b want 1", busy_o);
        end
      end
    end
    vec_cnt++;
    if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd42) begin
      err_cnt++;
      $display("FAIL b2b_second: got busy %b %h/%h want 0 0/2a", busy_o, hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    hilo_we_i = 1'b1; hilo_sel_i = 1'b1; hilo_wdata_i = 32'h1111;
    next_cycle();
    hilo_sel_i = 1'b0; hilo_wdata_i = 32'h2222;
    next_cycle();
    hilo_we_i = 1'b0;
    start_i = 1'b1; op_i = 2'd3; src_a_i = 32'd100; src_b_i = 32'd7;
    for (int k = 1; k <= 6; k++) begin
      next_cycle();
      start_i = 1'b0;
      reset   = (k == 5);
    end
    @(negedge clk);
    vec_cnt++;
    if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_mid: got busy %b %h/%h want 0 0/0", busy_o, hi_o, lo_o);
    end
    repeat (35) next_cycle();
    @(negedge clk);
    vec_cnt++;
    if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      err_cnt++;
      $display("FAIL reset_mid_late: got busy %b %h/%h want 0 0/0", busy_o, hi_o, lo_o);
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; op_i = 2'd0; src_a_i = 32'd0; src_b_i = 32'd0;
    flush_i = 1'b0; hilo_we_i = 1'b0; hilo_sel_i = 1'b0; hilo_wdata_i = 32'd0;
    rd_req_i = 1'b0;
    test_reset();
    test_mult_stall();
    test_ops();
    test_flush();
    test_wb_arb();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
